// File: rtl/usb_rx_dpll.sv
// USB receive front end: pin synchroniser, 4x-oversampling DPLL, NRZI decode,
// bit-unstuffing, SE0/EOP detection. One clock per quarter bit.
module usb_rx_dpll #(
  parameter bit          FULL_SPEED = 1'b1,
  parameter int unsigned STUFF_LEN  = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dp_i,
  input  logic dn_i,
  output logic rx_bit_o,
  output logic rx_valid_o,
  output logic se0_o,
  output logic eop_o,
  output logic stuff_err_o
);

  localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);
  localparam logic [OnesW-1:0] OnesMax = OnesW'(STUFF_LEN);

  // Idle (J) pin levels; low speed swaps J and K.
  localparam logic DpIdle = FULL_SPEED;
  localparam logic DnIdle = !FULL_SPEED;

  typedef enum logic [1:0] {LsJ, LsK, LsSe0} line_e;

  logic             dp_q1, dp_q2, dn_q1, dn_q2;
  line_e            ls_d, ls_q, ls_prev_q;
  logic [1:0]       phase_d, phase_q;
  logic [OnesW-1:0] ones_d, ones_q;
  line_e            nrzi_prev_d, nrzi_prev_q;
  logic [1:0]       se0_cnt_d, se0_cnt_q;
  logic             rx_bit_d, rx_valid_d, se0_d, eop_d, stuff_err_d;
  logic             edge_det, sample, nrzi_bit;

  // Two-flop synchroniser per pin, reset to the idle J levels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dp_q1 <= DpIdle;
      dp_q2 <= DpIdle;
      dn_q1 <= DnIdle;
      dn_q2 <= DnIdle;
    end else begin
      dp_q1 <= dp_i;
      dp_q2 <= dp_q1;
      dn_q1 <= dn_i;
      dn_q2 <= dn_q1;
    end
  end

  // Line-state decode of the synchronised pair; SE1 is folded into SE0.
  always_comb begin
    case ({dp_q2, dn_q2})
      2'b10:   ls_d = FULL_SPEED ? LsJ : LsK;
      2'b01:   ls_d = FULL_SPEED ? LsK : LsJ;
      default: ls_d = LsSe0;
    endcase
  end

  // An edge re-centres the phase; a sample lands two clocks later, mid-bit.
  assign edge_det = (ls_q != ls_prev_q);
  assign sample   = !edge_det && (phase_q == 2'd1);
  assign phase_d  = edge_det ? 2'd0 : phase_q + 2'd1;
  assign nrzi_bit = (ls_q == nrzi_prev_q);

  // Sample-point decode: NRZI, unstuffing, SE0 tracking and EOP.
  always_comb begin
    ones_d      = ones_q;
    nrzi_prev_d = nrzi_prev_q;
    se0_cnt_d   = se0_cnt_q;
    se0_d       = se0_o;
    rx_bit_d    = 1'b0;
    rx_valid_d  = 1'b0;
    eop_d       = 1'b0;
    stuff_err_d = 1'b0;
    if (sample) begin
      if (ls_q == LsSe0) begin
        se0_d       = 1'b1;
        se0_cnt_d   = (se0_cnt_q == 2'd3) ? 2'd3 : se0_cnt_q + 2'd1;
        ones_d      = '0;
        nrzi_prev_d = LsJ;
      end else begin
        se0_d     = 1'b0;
        se0_cnt_d = 2'd0;
        if (se0_cnt_q != 2'd0 && ls_q == LsJ) begin
          // J after SE0 closes the packet and carries no data.
          eop_d = 1'b1;
        end else begin
          nrzi_prev_d = ls_q;
          if (ones_q < OnesMax) begin
            rx_valid_d = 1'b1;
            rx_bit_d   = nrzi_bit;
            ones_d     = nrzi_bit ? ones_q + OnesW'(1) : '0;
          end else begin
            // Expected stuffed 0; a 1 here is a stuffing violation.
            stuff_err_d = nrzi_bit;
            ones_d      = '0;
          end
        end
      end
    end
  end

  // Line state, DPLL and decoder state plus registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ls_q        <= LsJ;
      ls_prev_q   <= LsJ;
      phase_q     <= 2'd0;
      ones_q      <= '0;
      nrzi_prev_q <= LsJ;
      se0_cnt_q   <= 2'd0;
      rx_bit_o    <= 1'b0;
      rx_valid_o  <= 1'b0;
      se0_o       <= 1'b0;
      eop_o       <= 1'b0;
      stuff_err_o <= 1'b0;
    end else begin
      ls_q        <= ls_d;
      ls_prev_q   <= ls_q;
      phase_q     <= phase_d;
      ones_q      <= ones_d;
      nrzi_prev_q <= nrzi_prev_d;
      se0_cnt_q   <= se0_cnt_d;
      rx_bit_o    <= rx_bit_d;
      rx_valid_o  <= rx_valid_d;
      se0_o       <= se0_d;
      eop_o       <= eop_d;
      stuff_err_o <= stuff_err_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_dpll.sv
// Bench for usb_rx_dpll: one full-speed and one low-speed instance. Expected
// outputs come from a timing/decode model of the line: each edge seen at the
// line-state stage anchors sample points 2, 6, 10... clocks later until the
// next edge; each sample is decoded by the NRZI/stuffing/EOP rules.
module tb_usb_rx_dpll;

  localparam int StuffLen = 6;

  typedef enum int {SymJ, SymK, SymSe0, SymSe1} sym_e;

  typedef struct {
    longint cyc;
    bit     valid;
    bit     dbit;
    bit     err;
    bit     eop;
    bit     se0;
  } rec_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n, dp, dn, rx_bit, rx_valid, se0, eop, stuff_err;
  int         errors = 0;
  int         checks = 0;
  longint     cyc = 0;
  longint     stop_cyc = 64'h7fff_ffff_ffff;

  // Model state per instance (line states: 0=J, 1=K, 2=SE0).
  int     m_ls[2], m_prev[2], m_ones[2], m_se0cnt[2];
  bit     m_se0[2], m_run[2], mon_se0[2];
  longint m_next[2];
  sym_e   tx[2];
  rec_t   q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_rx_dpll #(.FULL_SPEED(1'b1), .STUFF_LEN(StuffLen)) u_fs (
    .clk_i(clk), .rst_ni(rst_n[0]), .dp_i(dp[0]), .dn_i(dn[0]),
    .rx_bit_o(rx_bit[0]), .rx_valid_o(rx_valid[0]), .se0_o(se0[0]),
    .eop_o(eop[0]), .stuff_err_o(stuff_err[0])
  );

  usb_rx_dpll #(.FULL_SPEED(1'b0), .STUFF_LEN(StuffLen)) u_ls (
    .clk_i(clk), .rst_ni(rst_n[1]), .dp_i(dp[1]), .dn_i(dn[1]),
    .rx_bit_o(rx_bit[1]), .rx_valid_o(rx_valid[1]), .se0_o(se0[1]),
    .eop_o(eop[1]), .stuff_err_o(stuff_err[1])
  );

  function automatic int lstate(sym_e s);
    return (s == SymJ) ? 0 : (s == SymK) ? 1 : 2;
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic longint q_front_cyc(int i);
    return (i == 0) ? q0[0].cyc : q1[0].cyc;
  endfunction

  function automatic rec_t q_pop(int i);
    if (i == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic check(int i, string name, logic [4:0] got, logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%b expected=%b (valid,bit,err,eop,se0)",
               name, i, cyc, got, exp);
    end
  endtask

  // Decode one sample point at cycle t; the outputs show it at t+1.
  task automatic model_sample(int i, longint t);
    rec_t r;
    int   st;
    bit   b;
    st = m_ls[i];
    r.cyc = t + 1; r.valid = 0; r.dbit = 0; r.err = 0; r.eop = 0;
    if (st == 2) begin
      r.se0 = 1;
      m_se0[i] = 1;
      if (m_se0cnt[i] < 3) m_se0cnt[i]++;
      m_ones[i] = 0;
      m_prev[i] = 0;
    end else begin
      r.se0 = 0;
      if (m_se0cnt[i] >= 1 && st == 0) begin
        r.eop = 1;
      end else begin
        b = (st == m_prev[i]);
        m_prev[i] = st;
        if (m_ones[i] < StuffLen) begin
          r.valid = 1;
          r.dbit = b;
          m_ones[i] = b ? m_ones[i] + 1 : 0;
        end else begin
          r.err = b;
          m_ones[i] = 0;
        end
      end
      m_se0cnt[i] = 0;
      m_se0[i] = 0;
    end
    if (i == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic flush(int i, longint upto);
    if (!m_run[i]) return;
    while (m_next[i] < upto) begin
      model_sample(i, m_next[i]);
      m_next[i] += 4;
    end
  endtask

  // Pins changed in cycle c reach the line-state stage in cycle c+3.
  task automatic model_line(int i, sym_e s, longint c);
    longint a;
    a = c + 3;
    if (m_run[i] && lstate(s) != m_ls[i]) begin
      flush(i, a);
      m_ls[i] = lstate(s);
      m_next[i] = a + 2;
    end
  endtask

  task automatic pin_drive(int i, sym_e s);
    bit jdp;
    jdp = (i == 0);
    tx[i] = s;
    case (s)
      SymJ:    begin dp[i] = jdp;  dn[i] = !jdp; end
      SymK:    begin dp[i] = !jdp; dn[i] = jdp;  end
      SymSe0:  begin dp[i] = 1'b0; dn[i] = 1'b0; end
      default: begin dp[i] = 1'b1; dn[i] = 1'b1; end
    endcase
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      flush(0, cyc + 3);
      flush(1, cyc + 3);
    end
  endtask

  task automatic drive(int i, sym_e s, int n);
    pin_drive(i, s);
    model_line(i, s, cyc);
    tick(n);
  endtask

  // mode 0: 4 clocks/bit, 1: alternating 3/5, 2: random 3..5.
  task automatic send_bits(int i, bit [31:0] bits, int n, int mode);
    sym_e cur, nxt;
    int   dur;
    for (int k = 0; k < n; k++) begin
      cur = (tx[i] == SymK) ? SymK : SymJ;
      nxt = bits[k] ? cur : ((cur == SymJ) ? SymK : SymJ);
      dur = (mode == 0) ? 4 : (mode == 1) ? ((k % 2 == 0) ? 3 : 5) : int'($urandom_range(5, 3));
      drive(i, nxt, dur);
    end
  endtask

  task automatic send_sync(int i);
    sym_e seq[8];
    seq = '{SymK, SymJ, SymK, SymJ, SymK, SymJ, SymK, SymK};
    for (int k = 0; k < 8; k++) drive(i, seq[k], 4);
  endtask

  task automatic send_eop(int i, bit se1_mix);
    drive(i, SymSe0, 4);
    drive(i, se1_mix ? SymSe1 : SymSe0, 4);
    drive(i, SymJ, 12);
  endtask

  task automatic reset_assert(int i);
    rst_n[i] = 1'b0;
    m_run[i] = 0;
    mon_se0[i] = 0;
    if (i == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic reset_release(int i);
    rst_n[i] = 1'b1;
    m_run[i] = 1;
    m_ls[i] = 0; m_prev[i] = 0; m_ones[i] = 0; m_se0cnt[i] = 0; m_se0[i] = 0;
    m_next[i] = cyc + 1;
    model_line(i, tx[i], cyc);
  endtask

  task automatic mon(int i);
    rec_t       e;
    logic [4:0] got, exp;
    bit         have;
    if (rst_n[i] !== 1'b1 || cyc > stop_cyc) return;
    have = 0;
    got = {rx_valid[i], rx_bit[i] & rx_valid[i], stuff_err[i], eop[i], se0[i]};
    while (q_size(i) > 0 && q_front_cyc(i) < cyc) begin
      e = q_pop(i);
      checks++;
      errors++;
      $display("FAIL missed_sample dut%0d cyc=%0d expected at cyc=%0d", i, cyc, e.cyc);
    end
    if (q_size(i) > 0 && q_front_cyc(i) == cyc) begin
      e = q_pop(i);
      have = 1;
      mon_se0[i] = e.se0;
      exp = {e.valid, e.dbit, e.err, e.eop, e.se0};
    end else begin
      exp = {4'b0000, mon_se0[i]};
    end
    check(i, have ? "sample_point" : "between_samples", got, exp);
  endtask

  // Monitor: compares every cycle against the scoreboard queues.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) mon(i);
  end

  initial begin
    rst_n = 2'b00;
    m_run[0] = 0; m_run[1] = 0; mon_se0[0] = 0; mon_se0[1] = 0;
    pin_drive(0, SymJ);
    pin_drive(1, SymJ);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check(i, "reset_state",
            {rx_valid[i], rx_bit[i], stuff_err[i], eop[i], se0[i]}, 5'b00000);
    reset_release(0);
    reset_release(1);

    // Idle J: 6 ones, stuff error, repeat.
    tick(60);
    send_eop(0, 1'b0);
    // Six 1s, stuffed 0, then 1.
    send_bits(0, 32'b1011_1111, 8, 0);
    send_eop(0, 1'b0);
    send_sync(0);
    // 16 toggles with 3/5 clock jitter.
    send_bits(0, 32'h0, 16, 1);
    send_eop(0, 1'b1);
    for (int p = 0; p < 4; p++) begin
      send_sync(0);
      send_bits(0, $urandom(), 24, 2);
      send_eop(0, p[0]);
    end

    // Low-speed instance: packet, SE0, reset while SE0 is flagged.
    send_sync(1);
    send_bits(1, 32'h5a, 8, 0);
    drive(1, SymSe0, 6);
    reset_assert(1);
    #1;
    check(1, "reset_mid_packet",
          {rx_valid[1], rx_bit[1], stuff_err[1], eop[1], se0[1]}, 5'b00000);
    tick(1);
    reset_release(1);
    tick(4);
    drive(1, SymJ, 8);
    send_sync(1);
    send_bits(1, $urandom(), 20, 2);
    send_eop(1, 1'b0);
    tick(10);

    // Stop the model and the monitor at a common point, then drain.
    stop_cyc = cyc + 3;
    m_run[0] = 0;
    m_run[1] = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (q_size(i) != 0) begin
        errors++;
        $display("FAIL drain dut%0d pending=%0d expected 0", i, q_size(i));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
